slow_clk_gen: RTL and testbench
===============================

Name: slow_clk_gen

Overview:
- Downstream stage of the push-button frequency throttle. Consumes its 3-bit frequency level `freq_num` (0..5).
- Produces a programmable slow square wave `slow_clk`, plus a one-cycle `tick` enable, both in the CLK_50 domain.
- Rate changes take effect only at full-period boundaries, so downstream logic never sees a runt pulse.

Parameters:
- HALF0, 25000000, half-period in CLK_50 cycles at level 0 (1 Hz at 50 MHz); level k half-period = max(HALF0 >> k, 1).
- CNT_W, 32, width of the period counter; must hold HALF0-1.
- MAX_LVL, 5, highest legal level; larger freq_num values clamp to MAX_LVL.

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset, sampled on the CLK_50 rising edge.
- freq_num  in  3  requested frequency level from the throttle stage, same clock domain.
- slow_clk  out  1  divided square wave, 50% duty.
- tick  out  1  one-cycle pulse on each slow_clk rising edge.
- rate_cur  out  3  level currently in effect (clamped).
- rate_load  out  1  one-cycle pulse when a newly loaded level differs from the previous one.

Behaviour:
- Clock and reset: already decided, one clock (CLK_50); reset is synchronous and active-high.
- Reset values:
  - cnt=0, slow_clk=0, tick=0, rate_load=0.
  - rate_cur=clamp(freq_num) as sampled at the reset edge.
  - half_cur=max(HALF0>>rate_cur, 1).
- Counting:
  - Each non-reset cycle, if cnt==half_cur-1 then cnt<=0 and slow_clk toggles; else cnt<=cnt+1.
  - First slow_clk rise after reset release is registered half_cur cycles after the first non-reset edge.
- tick:
  - tick<=1 in the same edge where slow_clk goes 0->1; 0 otherwise. Exactly one cycle wide, aligned with slow_clk high.
  - When half_cur==1, slow_clk toggles every cycle and tick is high every other cycle.
- Rate load (period boundary):
  - Occurs only on the edge where slow_clk goes 1->0.
  - At that edge: rate_cur<=clamp(freq_num), half_cur<=max(HALF0>>clamp(freq_num),1), cnt<=0.
  - rate_load<=1 for one cycle if the new rate_cur != old rate_cur.
- freq_num changes mid-period: ignored until the next boundary. Only the value present at the boundary edge matters; intermediate values are discarded.
- Clamp: freq_num 6 or 7 is treated as 5 (MAX_LVL). rate_cur never exceeds MAX_LVL.
- Simultaneous events:
  - reset has priority over counting and loading.
  - Boundary load and toggle occur in the same edge; the new half_cur governs the next low phase.
- Reset mid-operation: on the next edge all state returns to reset values, regardless of phase. tick and rate_load are not asserted in that cycle.
- Arithmetic: cnt is unsigned CNT_W bits and never wraps (it is bounded by half_cur-1). The shift is a logical right shift of HALF0.

Optional Feature:
- Macro: SLOW_CLK_IMMEDIATE_EN.
- With the macro defined:
  - Any cycle where clamp(freq_num) != rate_cur loads the new rate immediately: cnt<=0, slow_clk<=0, tick<=0, rate_load<=1.
  - The period restarts from the low phase. A truncated high phase is permitted.
- Without the macro: loading only at the period boundary, as specified above.

Test Plan:
- Reset and level 0 (HALF0=32, freq_num=0): release reset → slow_clk rises at cycle 32 and falls at 64; tick is high only at cycle 32; period is 64; rate_cur=0.
- Level 5 (HALF0=32, freq_num=5 from reset): half_cur=1 → slow_clk toggles every cycle; tick every 2 cycles; rate_cur=5.
- Deferred change (HALF0=32, level 0): set freq_num=2 at cycle 40 (high phase) → no change until the falling edge at cycle 64; rate_load pulses there; the next rise is at 72 (half=8); rate_cur=2.
- Glitch filtering: within one period drive freq_num 0→3→1 and hold 1 at the boundary → rate_cur=1, half=16, one rate_load pulse. Holding freq_num equal to rate_cur at a boundary → no rate_load.
- Clamp: freq_num=7 → rate_cur=5, same waveform as level 5. Reset asserted mid high phase → slow_clk=0, cnt=0 on the next edge; restart as in the first scenario.
- With SLOW_CLK_IMMEDIATE_EN: at level 0, set freq_num=1 at cycle 40 → at cycle 41 slow_clk=0, cnt=0, rate_load=1; next rise at cycle 41+16.

Source files
------------

// File: rtl/slow_clk_gen.sv
// slow_clk_gen: programmable slow square wave with a rising-edge tick.
// Consumes a 3-bit frequency level (0..MAX_LVL, larger values clamp) and
// divides CLK_50 by 2*max(HALF0 >> level, 1). A new level is adopted only
// when slow_clk falls, so no runt pulses reach downstream logic.
// Optional macro SLOW_CLK_IMMEDIATE_EN: adopt a differing level on the very
// next edge and restart the period from its low phase.
module slow_clk_gen #(
  parameter int HALF0   = 25000000,
  parameter int CNT_W   = 32,
  parameter int MAX_LVL = 5
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic [2:0] freq_num,
  output logic       slow_clk,
  output logic       tick,
  output logic [2:0] rate_cur,
  output logic       rate_load
);

  localparam logic [2:0]       MAX_L  = 3'(MAX_LVL);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF0);

  // Clamp a requested level to the highest legal level.
  function automatic logic [2:0] clamp_lvl(input logic [2:0] lvl);
    logic [2:0] res;
    if (lvl > MAX_L) begin
      res = MAX_L;
    end else begin
      res = lvl;
    end
    return res;
  endfunction

  // Half-period for a level: logical shift of HALF0, never below one cycle.
  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] lvl);
    logic [CNT_W-1:0] h;
    h = HALF_C >> lvl;
    if (h == ZERO_C) begin
      h = ONE_C;
    end else begin
      h = h;
    end
    return h;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_cur_q, half_cur_d;
  logic [2:0]       rate_cur_q, rate_cur_d;
  logic             slow_clk_q, slow_clk_d;
  logic             tick_q, tick_d;
  logic             rate_load_q, rate_load_d;

  logic [2:0]       lvl_in_s;
  logic [CNT_W-1:0] half_in_s;
  logic             end_phase_s;

  // Clamped request and its half-period, used at reset and at loads.
  always_comb begin
    lvl_in_s  = clamp_lvl(freq_num);
    half_in_s = half_of(lvl_in_s);
  end

  // Next-state: period counting, toggling, tick and boundary rate load.
  always_comb begin
    cnt_d       = cnt_q;
    half_cur_d  = half_cur_q;
    rate_cur_d  = rate_cur_q;
    slow_clk_d  = slow_clk_q;
    tick_d      = 1'b0;
    rate_load_d = 1'b0;
    end_phase_s = (cnt_q == (half_cur_q - ONE_C));
`ifdef SLOW_CLK_IMMEDIATE_EN
    if (lvl_in_s != rate_cur_q) begin
      // Restart from the low phase at the new rate; high phase may be cut short.
      cnt_d       = ZERO_C;
      slow_clk_d  = 1'b0;
      rate_cur_d  = lvl_in_s;
      half_cur_d  = half_in_s;
      rate_load_d = 1'b1;
    end else if (end_phase_s) begin
      cnt_d      = ZERO_C;
      slow_clk_d = ~slow_clk_q;
      tick_d     = ~slow_clk_q;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
`else
    if (end_phase_s) begin
      cnt_d      = ZERO_C;
      slow_clk_d = ~slow_clk_q;
      tick_d     = ~slow_clk_q;
      if (slow_clk_q) begin
        // Falling edge is the period boundary: adopt the level seen now.
        rate_cur_d  = lvl_in_s;
        half_cur_d  = half_in_s;
        rate_load_d = (lvl_in_s != rate_cur_q);
      end else begin
        rate_load_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
`endif
  end

  // State registers with synchronous active-high reset taking priority.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      cnt_q       <= ZERO_C;
      slow_clk_q  <= 1'b0;
      tick_q      <= 1'b0;
      rate_load_q <= 1'b0;
      rate_cur_q  <= lvl_in_s;
      half_cur_q  <= half_in_s;
    end else begin
      cnt_q       <= cnt_d;
      slow_clk_q  <= slow_clk_d;
      tick_q      <= tick_d;
      rate_load_q <= rate_load_d;
      rate_cur_q  <= rate_cur_d;
      half_cur_q  <= half_cur_d;
    end
  end

  assign slow_clk  = slow_clk_q;
  assign tick      = tick_q;
  assign rate_cur  = rate_cur_q;
  assign rate_load = rate_load_q;

endmodule

// File: tb/tb_slow_clk_gen.sv
// Directed testbench for slow_clk_gen with HALF0=32.
// Edge numbering: after reset is released, the first rising edge is cycle 1.
module tb_slow_clk_gen;

  logic       CLK_50;
  logic       reset;
  logic [2:0] freq_num;
  logic       slow_clk;
  logic       tick;
  logic [2:0] rate_cur;
  logic       rate_load;

  int checks;
  int errors;
  int cyc;

  slow_clk_gen #(.HALF0(32), .CNT_W(32), .MAX_LVL(5)) dut (
    .CLK_50   (CLK_50),
    .reset    (reset),
    .freq_num (freq_num),
    .slow_clk (slow_clk),
    .tick     (tick),
    .rate_cur (rate_cur),
    .rate_load(rate_load)
  );

  // 100 MHz-style bench clock; only edge counts matter.
  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic adv1();
    @(posedge CLK_50);
    #1;
    cyc = cyc + 1;
  endtask

  // Advance until just after edge number n.
  task automatic adv_to(input int n);
    while (cyc < n) adv1();
  endtask

  // One reset edge with the given level, then release; cyc restarts at 0.
  task automatic do_reset(input logic [2:0] lvl);
    reset    = 1'b1;
    freq_num = lvl;
    adv1();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    reset    = 1'b1;
    freq_num = 3'd0;

    // Scenario 1: reset state and level 0 (half 32, period 64)
    do_reset(3'd0);
    check_val("rst_slow", 32'(slow_clk), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_load", 32'(rate_load), 32'd0);
    check_val("rst_rate", 32'(rate_cur), 32'd0);
    adv_to(31);
    check_val("l0_low31", 32'(slow_clk), 32'd0);
    check_val("l0_notick31", 32'(tick), 32'd0);
    adv_to(32);
    check_val("l0_rise32", 32'(slow_clk), 32'd1);
    check_val("l0_tick32", 32'(tick), 32'd1);
    adv_to(33);
    check_val("l0_tick33", 32'(tick), 32'd0);
    check_val("l0_high33", 32'(slow_clk), 32'd1);
    adv_to(64);
    check_val("l0_fall64", 32'(slow_clk), 32'd0);
    check_val("l0_noload64", 32'(rate_load), 32'd0);
    adv_to(96);
    check_val("l0_rise96", 32'(slow_clk), 32'd1);
    check_val("l0_tick96", 32'(tick), 32'd1);

    // Scenario 2: level 5 from reset, toggles every cycle
    do_reset(3'd5);
    check_val("l5_rate", 32'(rate_cur), 32'd5);
    adv1();
    check_val("l5_c1_slow", 32'(slow_clk), 32'd1);
    check_val("l5_c1_tick", 32'(tick), 32'd1);
    adv1();
    check_val("l5_c2_slow", 32'(slow_clk), 32'd0);
    check_val("l5_c2_tick", 32'(tick), 32'd0);
    adv1();
    check_val("l5_c3_tick", 32'(tick), 32'd1);

`ifndef SLOW_CLK_IMMEDIATE_EN
    // Scenario 3: deferred change requested in the high phase
    do_reset(3'd0);
    adv_to(39);
    freq_num = 3'd2;
    adv_to(63);
    check_val("def_rate63", 32'(rate_cur), 32'd0);
    check_val("def_high63", 32'(slow_clk), 32'd1);
    adv_to(64);
    check_val("def_fall64", 32'(slow_clk), 32'd0);
    check_val("def_load64", 32'(rate_load), 32'd1);
    check_val("def_rate64", 32'(rate_cur), 32'd2);
    adv_to(65);
    check_val("def_load65", 32'(rate_load), 32'd0);
    adv_to(71);
    check_val("def_low71", 32'(slow_clk), 32'd0);
    adv_to(72);
    check_val("def_rise72", 32'(slow_clk), 32'd1);
    check_val("def_tick72", 32'(tick), 32'd1);

    // Scenario 4: glitch filtering 2 -> 3 -> 1 within the period ending at 80
    adv_to(73);
    freq_num = 3'd3;
    adv_to(75);
    freq_num = 3'd1;
    adv_to(79);
    check_val("gl_rate79", 32'(rate_cur), 32'd2);
    adv_to(80);
    check_val("gl_fall80", 32'(slow_clk), 32'd0);
    check_val("gl_rate80", 32'(rate_cur), 32'd1);
    check_val("gl_load80", 32'(rate_load), 32'd1);
    adv_to(81);
    check_val("gl_load81", 32'(rate_load), 32'd0);
    adv_to(95);
    check_val("gl_low95", 32'(slow_clk), 32'd0);
    adv_to(96);
    check_val("gl_rise96", 32'(slow_clk), 32'd1);
    adv_to(112);
    check_val("gl_fall112", 32'(slow_clk), 32'd0);
    check_val("gl_sameload112", 32'(rate_load), 32'd0);
    check_val("gl_rate112", 32'(rate_cur), 32'd1);
`else
    // Immediate mode: change at cycle 40 takes effect at edge 41
    do_reset(3'd0);
    adv_to(40);
    freq_num = 3'd1;
    adv_to(41);
    check_val("imm_slow41", 32'(slow_clk), 32'd0);
    check_val("imm_load41", 32'(rate_load), 32'd1);
    check_val("imm_rate41", 32'(rate_cur), 32'd1);
    adv_to(42);
    check_val("imm_load42", 32'(rate_load), 32'd0);
    adv_to(56);
    check_val("imm_low56", 32'(slow_clk), 32'd0);
    adv_to(57);
    check_val("imm_rise57", 32'(slow_clk), 32'd1);
    check_val("imm_tick57", 32'(tick), 32'd1);
`endif

    // Scenario 5: clamp 7 -> 5
    do_reset(3'd7);
    check_val("clp_rate", 32'(rate_cur), 32'd5);
    adv1();
    check_val("clp_c1_slow", 32'(slow_clk), 32'd1);
    check_val("clp_c1_tick", 32'(tick), 32'd1);
    adv1();
    check_val("clp_c2_slow", 32'(slow_clk), 32'd0);
    adv1();
    check_val("clp_rate3", 32'(rate_cur), 32'd5);

    // Scenario 6: reset asserted during a high phase, then restart
    do_reset(3'd0);
    adv_to(40);
    check_val("mr_high40", 32'(slow_clk), 32'd1);
    reset = 1'b1;
    adv1();
    check_val("mr_slow", 32'(slow_clk), 32'd0);
    check_val("mr_tick", 32'(tick), 32'd0);
    check_val("mr_load", 32'(rate_load), 32'd0);
    reset = 1'b0;
    cyc   = 0;
    adv_to(31);
    check_val("mr_low31", 32'(slow_clk), 32'd0);
    adv_to(32);
    check_val("mr_rise32", 32'(slow_clk), 32'd1);
    check_val("mr_tick32", 32'(tick), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
